// File: rtl/alu_sequencer_if.sv
// Handshake and operand/result bundle between a requester and the ALU sequencer.
interface alu_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [2:0]       op;
  logic             dest;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] c_in;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_c;
  logic [2:0]       alu_fn;
  logic             alu_en;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic [WIDTH-1:0] reg_a;
  logic [WIDTH-1:0] reg_d;
  logic             flag_z;
  logic             flag_c;
  logic             flag_s;
  logic             busy;
  logic             done;

  modport slave (
    input  start, op, dest, b_in, c_in, alu_result, alu_carry,
    output alu_b, alu_c, alu_fn, alu_en, reg_a, reg_d,
           flag_z, flag_c, flag_s, busy, done
  );

  modport master (
    output start, op, dest, b_in, c_in, alu_result, alu_carry,
    input  alu_b, alu_c, alu_fn, alu_en, reg_a, reg_d,
           flag_z, flag_c, flag_s, busy, done
  );
endinterface

// File: rtl/alu_sequencer.sv
// Sequences one ALU operation: capture operands, wait for relay settle, latch result.
// Condition flags are built only when ALU_SEQ_FLAGS_EN is defined.
module alu_sequencer #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input logic           clk,
  input logic           reset,
  alu_sequencer_if.slave bus
);
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_INC = 3'd1;
  localparam logic [2:0] OP_SHL = 3'd6;

  typedef enum logic [1:0] {IDLE, SETTLE, LATCH, DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             dest_q, dest_d;
  logic [2:0]       fn_q, fn_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0] rega_q, rega_d;
  logic [WIDTH-1:0] regd_q, regd_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dest_q  <= 1'b0;
      fn_q    <= '0;
      b_q     <= '0;
      c_q     <= '0;
      rega_q  <= '0;
      regd_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dest_q  <= dest_d;
      fn_q    <= fn_d;
      b_q     <= b_d;
      c_q     <= c_d;
      rega_q  <= rega_d;
      regd_q  <= regd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dest_d  = dest_q;
    fn_d    = fn_q;
    b_d     = b_q;
    c_d     = c_q;
    rega_d  = rega_q;
    regd_d  = regd_q;
    case (state_q)
      IDLE: if (bus.start) begin
        fn_d    = bus.op;
        b_d     = bus.b_in;
        c_d     = bus.c_in;
        dest_d  = bus.dest;
        cnt_d   = 4'(SETTLE_CYCLES - 1);
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == 4'd0) state_d = LATCH;
        else               cnt_d   = cnt_q - 4'd1;
      end
      LATCH: begin
        if (dest_q) regd_d = bus.alu_result;
        else        rega_d = bus.alu_result;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.alu_b  = b_q;
  assign bus.alu_c  = c_q;
  assign bus.alu_fn = fn_q;
  assign bus.alu_en = (state_q == SETTLE) || (state_q == LATCH);
  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.reg_a  = rega_q;
  assign bus.reg_d  = regd_q;

`ifdef ALU_SEQ_FLAGS_EN
  logic fz_q, fz_d, fc_q, fc_d, fs_q, fs_d;

  // Only arithmetic-style functions produce a meaningful carry out.
  always_comb begin
    fz_d = fz_q;
    fc_d = fc_q;
    fs_d = fs_q;
    if (state_q == LATCH) begin
      fz_d = (bus.alu_result == '0);
      fs_d = bus.alu_result[WIDTH-1];
      fc_d = ((fn_q == OP_ADD) || (fn_q == OP_INC) || (fn_q == OP_SHL)) && bus.alu_carry;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fz_q <= 1'b0;
      fc_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      fz_q <= fz_d;
      fc_q <= fc_d;
      fs_q <= fs_d;
    end
  end

  assign bus.flag_z = fz_q;
  assign bus.flag_c = fc_q;
  assign bus.flag_s = fs_q;
`else
  logic       unused_carry;
  logic [2:0] unused_ops;
  assign unused_carry = bus.alu_carry;
  assign unused_ops   = OP_ADD | OP_INC | OP_SHL;
  assign bus.flag_z   = 1'b0;
  assign bus.flag_c   = 1'b0;
  assign bus.flag_s   = 1'b0;
`endif
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: SETTLE_CYCLES=4 main instance plus a SETTLE_CYCLES=1 instance.
module tb_alu_sequencer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_sequencer_if #(.WIDTH(8)) bus ();
  alu_sequencer_if #(.WIDTH(8)) bus1 ();

  alu_sequencer #(.WIDTH(8), .SETTLE_CYCLES(4)) dut  (.clk(clk), .reset(reset), .bus(bus));
  alu_sequencer #(.WIDTH(8), .SETTLE_CYCLES(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

`ifdef ALU_SEQ_FLAGS_EN
  localparam logic FL = 1'b1;
`else
  localparam logic FL = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic d, input logic [7:0] b, input logic [7:0] c,
                       input logic [7:0] r, input logic cy);
    bus.start      = 1'b1;
    bus.op         = op;
    bus.dest       = d;
    bus.b_in       = b;
    bus.c_in       = c;
    bus.alu_result = r;
    bus.alu_carry  = cy;
  endtask

  // Leaves the bench in cycle 6 (the DONE cycle) of the issued operation.
  task automatic run_op(input logic [2:0] op, input logic d, input logic [7:0] b, input logic [7:0] c,
                        input logic [7:0] r, input logic cy);
    issue(op, d, b, c, r, cy);
    tick;
    bus.start = 1'b0;
    repeat (5) tick;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_done"}, 32'(bus.done), 0);
    check({tag, "_en"},   32'(bus.alu_en), 0);
    check({tag, "_b"},    32'(bus.alu_b), 0);
    check({tag, "_c"},    32'(bus.alu_c), 0);
    check({tag, "_fn"},   32'(bus.alu_fn), 0);
    check({tag, "_rega"}, 32'(bus.reg_a), 0);
    check({tag, "_regd"}, 32'(bus.reg_d), 0);
    check({tag, "_flags"}, 32'({bus.flag_z, bus.flag_c, bus.flag_s}), 0);
  endtask

  initial begin
    reset = 1'b1;
    issue(3'd0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    bus.start = 1'b0;
    bus1.start = 1'b0; bus1.op = 3'd0; bus1.dest = 1'b0;
    bus1.b_in = 8'h00; bus1.c_in = 8'h00; bus1.alu_result = 8'h00; bus1.alu_carry = 1'b0;
    #12;
    check_all_zero("rst");

    // Release reset between edges; the very next edge must accept the start.
    tick;
    reset = 1'b0;
    issue(3'd2, 1'b0, 8'hF0, 8'h3C, 8'h30, 1'b0);
    tick;  // cycle 1
    bus.start = 1'b0;
    bus.b_in = 8'h11; bus.c_in = 8'h22; bus.op = 3'd7; bus.dest = 1'b1;
    check("and_fn", 32'(bus.alu_fn), 2);
    check("and_b",  32'(bus.alu_b), 32'h F0);
    check("and_c",  32'(bus.alu_c), 32'h3C);
    check("and_busy", 32'(bus.busy), 1);
    for (int c = 1; c <= 6; c++) begin
      check($sformatf("and_done_c%0d", c), 32'(bus.done), 32'(c == 6));
      check($sformatf("and_en_c%0d", c), 32'(bus.alu_en), 32'(c <= 5));
      if (c < 6) tick;
    end
    check("and_rega", 32'(bus.reg_a), 32'h30);
    check("and_regd", 32'(bus.reg_d), 0);
    check("and_flags", 32'({bus.flag_z, bus.flag_c, bus.flag_s}), 0);
    tick;  // cycle 7
    check("and_done_c7", 32'(bus.done), 0);
    check("and_idle", 32'(bus.busy), 0);
    check("and_fn_hold", 32'(bus.alu_fn), 2);
    check("and_b_hold", 32'(bus.alu_b), 32'hF0);

    run_op(3'd4, 1'b1, 8'h0F, 8'h8F, 8'h80, 1'b1);
    check("xor_done", 32'(bus.done), 1);
    check("xor_regd", 32'(bus.reg_d), 32'h80);
    check("xor_rega", 32'(bus.reg_a), 32'h30);
    check("xor_fz", 32'(bus.flag_z), 0);
    check("xor_fc", 32'(bus.flag_c), 0);
    check("xor_fs", 32'(bus.flag_s), 32'(FL));
    tick;

    run_op(3'd0, 1'b1, 8'hFF, 8'h01, 8'h00, 1'b1);
    check("add_done", 32'(bus.done), 1);
    check("add_regd", 32'(bus.reg_d), 0);
    check("add_rega", 32'(bus.reg_a), 32'h30);
    check("add_fz", 32'(bus.flag_z), 32'(FL));
    check("add_fc", 32'(bus.flag_c), 32'(FL));
    check("add_fs", 32'(bus.flag_s), 0);
    tick;

    // start held for cycles 0..19: accepts at 0, 7, 14 -> done at 6, 13, 20.
    issue(3'd3, 1'b0, 8'h01, 8'h02, 8'h12, 1'b0);
    for (int c = 1; c <= 20; c++) begin
      tick;
      if (c == 20) bus.start = 1'b0;
      check($sformatf("hold_done_c%0d", c), 32'(bus.done), 32'(c == 6 || c == 13 || c == 20));
      if (c <= 6) check($sformatf("hold_busy_c%0d", c), 32'(bus.busy), 1);
      if (c == 7) check("hold_busy_c7", 32'(bus.busy), 0);
    end
    check("hold_rega", 32'(bus.reg_a), 32'h12);
    tick;

    run_op(3'd3, 1'b0, 8'h50, 8'h05, 8'h55, 1'b0);
    check("pre_rega", 32'(bus.reg_a), 32'h55);
    tick;
    issue(3'd3, 1'b0, 8'hA0, 8'h0A, 8'hAA, 1'b0);
    tick;  // cycle 1
    bus.start = 1'b0;
    tick;
    tick;  // cycle 3
    reset = 1'b1;
    #1;
    check_all_zero("abort");
    tick;
    tick;
    check("abort_done_rst", 32'(bus.done), 0);
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick;
      check($sformatf("abort_done_%0d", c), 32'(bus.done), 0);
      check($sformatf("abort_rega_%0d", c), 32'(bus.reg_a), 0);
    end

    // SETTLE_CYCLES=1 instance.
    bus1.start = 1'b1; bus1.op = 3'd1; bus1.dest = 1'b1;
    bus1.b_in = 8'h7D; bus1.alu_result = 8'h7E;
    tick;  // cycle 1
    bus1.start = 1'b0;
    check("s1_en_c1", 32'(bus1.alu_en), 1);
    check("s1_done_c1", 32'(bus1.done), 0);
    tick;
    check("s1_en_c2", 32'(bus1.alu_en), 1);
    check("s1_done_c2", 32'(bus1.done), 0);
    tick;
    check("s1_en_c3", 32'(bus1.alu_en), 0);
    check("s1_done_c3", 32'(bus1.done), 1);
    check("s1_regd", 32'(bus1.reg_d), 32'h7E);
    tick;
    check("s1_done_c4", 32'(bus1.done), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, the operand and result width in bits.
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 4, the number of relay settle cycles (legal range 1..15).
REQ-003 The block SHALL have port clk  input  1  system clock, rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port start  input  1  operation request, sampled only in IDLE.
REQ-006 The block SHALL have port op  input  3  function: 0 ADD, 1 INC, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 SHL, 7 CLR.
REQ-007 The block SHALL have port dest  input  1  destination: 0 = reg_a, 1 = reg_d.
REQ-008 The block SHALL have port b_in and port c_in, each input  WIDTH  operands B and C.
REQ-009 The block SHALL have port alu_b and port alu_c, each output  WIDTH  registered operands driven to the logic/adder blocks.
REQ-010 The block SHALL have port alu_fn  output  3  registered function select; alu_en  output  1  function-enable strobe.
REQ-011 The block SHALL have port alu_result  input  WIDTH and alu_carry  input  1, returned from the datapath.
REQ-012 The block SHALL have port reg_a and port reg_d, each output  WIDTH  destination registers.
REQ-013 The block SHALL have outputs flag_z, flag_c and flag_s, each 1 bit: zero, carry and sign condition flags.
REQ-014 The block SHALL have outputs busy and done, each 1 bit.

Function
REQ-015 The FSM SHALL have states IDLE, SETTLE, LATCH and DONE.
REQ-016 On the edge where state is IDLE and start=1, the block SHALL capture op into alu_fn, b_in into alu_b, c_in into alu_c and dest internally, load the counter with SETTLE_CYCLES-1, and go to SETTLE.
REQ-017 SETTLE SHALL decrement the counter each cycle and go to LATCH on the edge where the counter is 0, so SETTLE lasts exactly SETTLE_CYCLES cycles.
REQ-018 alu_en SHALL be 1 in SETTLE and LATCH and 0 otherwise.
REQ-019 On the LATCH edge, the block SHALL write alu_result to the selected destination register and go to DONE; the other register SHALL hold its value.
REQ-020 The same LATCH edge SHALL set flag_z = (alu_result == 0) and flag_s = alu_result[WIDTH-1].
REQ-021 The same LATCH edge SHALL set flag_c = alu_carry for op ADD, INC and SHL, and 0 for all other op values.
REQ-022 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-023 Latency: for start accepted in cycle N, done=1 in cycle N+SETTLE_CYCLES+2, and the new register and flag values SHALL be visible in that same cycle.
REQ-024 busy SHALL be 1 in every state other than IDLE.
REQ-025 start while busy=1 (including DONE) SHALL be ignored, not queued.
REQ-026 alu_b, alu_c and alu_fn SHALL hold stable from capture until the next accepted start.
REQ-027 Changes on b_in, c_in, op and dest after capture SHALL have no effect on the operation in progress.

Reset
REQ-028 Asserting reset SHALL immediately force state IDLE, counter 0, and all outputs (alu_b, alu_c, alu_fn, alu_en, reg_a, reg_d, flags, busy, done) to 0.
REQ-029 Reset asserted mid-operation SHALL abort it, with no register or flag write.
REQ-030 The first start SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-031 With macro ALU_SEQ_FLAGS_EN defined, flag_z, flag_c and flag_s SHALL behave per REQ-020 and REQ-021.
REQ-032 Without ALU_SEQ_FLAGS_EN, the three flags SHALL be tied to 0 and the block SHALL contain no flag registers; all other behaviour SHALL be unchanged.

Verification
REQ-033 Scenario: SETTLE_CYCLES=4, start in cycle 0, op=AND, b=0xF0, c=0x3C, dest=0, alu_result=0x30 -> done in cycle 6 only, reg_a=0x30, reg_d unchanged, flag_z=0, flag_s=0, flag_c=0.
REQ-034 Scenario: op=ADD, b=0xFF, c=0x01, dest=1, alu_result=0x00, alu_carry=1 -> reg_d=0x00, flag_z=1, flag_c=1, flag_s=0.
REQ-035 Scenario: start held high continuously for 20 cycles -> operations accepted in cycles 0, 7 and 14 only; busy stays 1 from cycle 1 through cycle 6.
REQ-036 Scenario: reset asserted in cycle 3 of an op with dest=0 and prior reg_a=0x55 -> all outputs 0 immediately, no done pulse, reg_a=0x00.
REQ-037 Scenario: op=XOR with alu_carry forced to 1 and alu_result=0x80 -> flag_c=0, flag_s=1; without ALU_SEQ_FLAGS_EN all three flags read 0.
REQ-038 Scenario: SETTLE_CYCLES=1, start in cycle 0 -> alu_en=1 in cycles 1 and 2, done=1 in cycle 3.
